// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer.
// Fetches sequential 32-bit words from a combinational instruction ROM into a
// DEPTH-entry FIFO of {pc, inst}. The decode stage consumes the FIFO head.
// A flush redirects fetching to new_pc and discards everything buffered.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   stall     downstream not accepting; blocks pop
//   flush     redirect request, sampled at the rising edge
//   new_pc    redirect target, used when flush=1
//   rom_ce    fetch issued this cycle (combinational)
//   rom_addr  fetch byte address = fetch_pc (combinational)
//   rom_inst  ROM read data for rom_addr, same cycle
//   if_valid  FIFO head holds a valid instruction
//   if_pc     head instruction address, 0 when empty
//   if_inst   head instruction word, 0 when empty
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];

    logic pop;
    logic full;
    logic push;

    // Handshake terms; a full buffer still accepts a push when it pops the same edge.
    assign full     = (count == CNT_W'(DEPTH));
    assign if_valid = (count != '0);
    assign pop      = if_valid & ~stall & ~flush;
    assign rom_ce   = ~rst & ~flush & (~full | pop);
    assign push     = rom_ce;
    assign rom_addr = fetch_pc;

    // Head presentation comes only from stored entries, never from rom_inst.
    assign if_pc   = if_valid ? mem_pc[rd_ptr]   : 32'h0;
    assign if_inst = if_valid ? mem_inst[rd_ptr] : 32'h0;

    // Control state: fetch address, pointers, occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            fetch_pc <= new_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= fetch_pc;
            mem_inst[wr_ptr] <= rom_inst;
        end
    end

endmodule
